lms_ctr_pio_ext: RTL

Parametrised general-purpose I/O port for the lms_ctr Nios subsystem, an Avalon-MM slave on the CPU data bus. It provides a WIDTH-bit output register with atomic set/clear aliases, a per-bit direction register, and a synchronised input path. Optional edge-capture with a maskable level interrupt is compiled in by macro. It replaces single-bit output-only PIOs for board control and status lines such as LMS resets, LEDs, and PLL lock inputs.

---
 rtl/lms_ctr_pio_ext.sv | 118 +++++++++++
 1 files changed

// File: rtl/lms_ctr_pio_ext.sv
// Avalon-MM GPIO port: output register with set/clear aliases, direction register, synchronised inputs.
// Define LMS_CTR_PIO_EDGE_IRQ_EN to build in edge capture, the IRQ mask and the level interrupt.
module lms_ctr_pio_ext #(
  parameter int unsigned          WIDTH     = 8,
  parameter logic [WIDTH-1:0]     RESET_OUT = '0,
  parameter logic [WIDTH-1:0]     RESET_DIR = '0,
  parameter int unsigned          EDGE_TYPE = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe_port,
  output logic             irq
);

  logic             wr;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] s1_q, s2_q;
  logic [WIDTH-1:0] mask_rd, cap_rd;

  assign wr = chipselect & ~write_n;
  assign wd = writedata[WIDTH-1:0];

  always_comb begin
    out_d = out_q;
    dir_d = dir_q;
    if (wr) begin
      case (address)
        3'd0:    out_d = wd;
        3'd1:    dir_d = wd;
        3'd4:    out_d = out_q | wd;
        3'd5:    out_d = out_q & ~wd;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q <= RESET_OUT;
      dir_q <= RESET_DIR;
      s1_q  <= '0;
      s2_q  <= '0;
    end else begin
      out_q <= out_d;
      dir_q <= dir_d;
      s1_q  <= in_port;
      s2_q  <= s1_q;
    end
  end

`ifdef LMS_CTR_PIO_EDGE_IRQ_EN
  logic [WIDTH-1:0] s3_q;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] clr;

  always_comb begin
    case (EDGE_TYPE)
      0:       edge_det = s2_q & ~s3_q;
      1:       edge_det = ~s2_q & s3_q;
      default: edge_det = s2_q ^ s3_q;
    endcase
  end

  // A new edge overrides a simultaneous write-1-to-clear of the same bit.
  always_comb begin
    clr    = (wr && address == 3'd3) ? wd : '0;
    mask_d = (wr && address == 3'd2) ? wd : mask_q;
    cap_d  = (cap_q & ~clr) | edge_det;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s3_q   <= '0;
      mask_q <= '0;
      cap_q  <= '0;
    end else begin
      s3_q   <= s2_q;
      mask_q <= mask_d;
      cap_q  <= cap_d;
    end
  end

  assign irq     = |(cap_q & mask_q);
  assign mask_rd = mask_q;
  assign cap_rd  = cap_q;
`else
  assign irq     = 1'b0;
  assign mask_rd = '0;
  assign cap_rd  = '0;
`endif

  always_comb begin
    readdata = '0;
    case (address)
      3'd0:    readdata[WIDTH-1:0] = (dir_q & out_q) | (~dir_q & s2_q);
      3'd1:    readdata[WIDTH-1:0] = dir_q;
      3'd2:    readdata[WIDTH-1:0] = mask_rd;
      3'd3:    readdata[WIDTH-1:0] = cap_rd;
      3'd6:    readdata[WIDTH-1:0] = s2_q;
      default: ;
    endcase
  end

  assign out_port = out_q;
  assign oe_port  = dir_q;

endmodule
